// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and op encoding for the ALU op sequencer.
package alu_seq_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_CMP = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   // Returns {s1, s0} for the ALU select pins.
   function automatic logic [1:0] op_to_sel(input logic [1:0] op);
      logic [1:0] sel;
      case (op)
         OP_ADD:  sel = 2'b00;
         OP_SUB:  sel = 2'b01;
         OP_CMP:  sel = 2'b10;
         default: sel = 2'b11;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-pin and result streams between the sequencer and its environment.
interface alu_op_sequencer_if #(
   parameter int TAG_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [3:0]       cmd_a;
   logic [3:0]       cmd_b;
   logic             alu_s0;
   logic             alu_s1;
   logic [3:0]       alu_a;
   logic [3:0]       alu_b;
   logic             alu_en;
   logic [4:0]       alu_y;
   logic             res_valid;
   logic             res_ready;
   logic [4:0]       res_data;
   logic [1:0]       res_op;
   logic [TAG_W-1:0] res_tag;

   modport master (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, res_ready,
      output cmd_ready, alu_s0, alu_s1, alu_a, alu_b, alu_en,
             res_valid, res_data, res_op, res_tag
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a, cmd_b, alu_y, res_ready,
      input  cmd_ready, alu_s0, alu_s1, alu_a, alu_b, alu_en,
             res_valid, res_data, res_op, res_tag
   );
endinterface

// File: rtl/alu_res_fifo.sv
// Small synchronous result FIFO; head entry is presented straight from registered storage.
module alu_res_fifo #(
   parameter  int W     = 10,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage is reset too so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the 4-bit ALU for a settle window per command and queues tagged results.
//  state | meaning
//  IDLE  | ALU pins low; accept a command when a FIFO slot is free
//  DRIVE | ALU pins driven from latched command; push result when counter hits 0
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int RES_DEPTH     = 4,
   parameter int TAG_W         = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_op_sequencer_if.master  bus,
   output logic                busy
);
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int CW    = $clog2(RES_DEPTH) + 1;
   localparam int FW    = 5 + 2 + TAG_W;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [TAG_W-1:0] cmd_tag_q, cmd_tag_d;
   logic [1:0]       op_q, op_d;
   logic [3:0]       a_q, a_d;
   logic [3:0]       b_q, b_d;
   logic [1:0]       sel;

   logic             accept;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [FW-1:0]    fifo_din;
   logic [FW-1:0]    fifo_dout;

   // Accepting only in IDLE with a free slot reserves room for the in-flight result.
   assign accept   = (state_q == IDLE) && bus.cmd_valid && !fifo_full;
   assign push     = (state_q == DRIVE) && (cnt_q == '0);
   assign pop      = !fifo_empty && bus.res_ready;
   assign fifo_din = {bus.alu_y, op_q, cmd_tag_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tag_q     <= '0;
         cmd_tag_q <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tag_q     <= tag_d;
         cmd_tag_q <= cmd_tag_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tag_d     = tag_q;
      cmd_tag_d = cmd_tag_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               op_d      = bus.cmd_op;
               a_d       = bus.cmd_a;
               b_d       = bus.cmd_b;
               cmd_tag_d = tag_q;
               tag_d     = tag_q + 1'b1;
               cnt_d     = CNT_LOAD;
               state_d   = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready = 1'b0;
      bus.alu_en    = 1'b0;
      bus.alu_a     = 4'd0;
      bus.alu_b     = 4'd0;
      sel           = 2'b00;
      unique case (state_q)
         IDLE:  bus.cmd_ready = !fifo_full;
         DRIVE: begin
            bus.alu_en = 1'b1;
            bus.alu_a  = a_q;
            bus.alu_b  = b_q;
            sel        = op_to_sel(op_q);
         end
         default: ;
      endcase
      bus.alu_s1 = sel[1];
      bus.alu_s0 = sel[0];
   end

   assign bus.res_valid = !fifo_empty;
   assign {bus.res_data, bus.res_op, bus.res_tag} = fifo_dout;
   assign busy = (state_q != IDLE) || (fifo_count != '0);

   alu_res_fifo #(
      .W     (FW),
      .DEPTH (RES_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU on the pins, queue-based result model.
module tb_alu_op_sequencer;

   logic clk = 1'b0;
   logic rst1_n;
   logic rst3_n;
   logic busy1;
   logic busy3;

   always #5 clk = ~clk;

   alu_op_sequencer_if #(.TAG_W(3)) c1 ();
   alu_op_sequencer_if #(.TAG_W(3)) c3 ();

   alu_op_sequencer #(.SETTLE_CYCLES(1), .RES_DEPTH(4), .TAG_W(3)) dut1 (
      .clk (clk), .rst_n (rst1_n), .bus (c1.master), .busy (busy1)
   );
   alu_op_sequencer #(.SETTLE_CYCLES(3), .RES_DEPTH(4), .TAG_W(3)) dut3 (
      .clk (clk), .rst_n (rst3_n), .bus (c3.master), .busy (busy3)
   );

   int compared = 0;
   int mism     = 0;

   // Behavioural ALU: {s1,s0} 00 add, 01 sub, 10 compare {gt,eq}, 11 AND.
   function automatic logic [4:0] alu_ref(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
      case (sel)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {1'b0, a} - {1'b0, b};
         2'b10:   return {3'b000, (a > b), (a == b)};
         default: return {1'b0, a & b};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always_comb c1.alu_y = c1.alu_en ? alu_ref({c1.alu_s1, c1.alu_s0}, c1.alu_a, c1.alu_b) : 5'd0;

   // The slow ALU only shows the true result once enable has been high for 3 cycles.
   logic [3:0] en3_cnt = 4'd0;
   always @(posedge clk) en3_cnt <= c3.alu_en ? en3_cnt + 4'd1 : 4'd0;
   always_comb begin
      c3.alu_y = 5'd0;
      if (c3.alu_en)
         c3.alu_y = (en3_cnt >= 4'd2) ? alu_ref({c3.alu_s1, c3.alu_s0}, c3.alu_a, c3.alu_b)
                                      : ~alu_ref({c3.alu_s1, c3.alu_s0}, c3.alu_a, c3.alu_b);
   end

   typedef struct packed {
      logic [4:0] data;
      logic [1:0] op;
      logic [2:0] tag;
   } exp_t;

   exp_t       exp_q[$];
   logic [2:0] mtag      = 3'd0;
   logic [2:0] last_tag  = 3'd0;
   int         pops      = 0;
   bit         hold_prev = 1'b0;
   logic [9:0] prev_res  = '0;

   task automatic model_reset();
      exp_q.delete();
      mtag      = 3'd0;
      pops      = 0;
      hold_prev = 1'b0;
   endtask

   // Scoreboard for dut1: accepted commands enter the queue, pops must match its head in order.
   always @(negedge clk) begin
      exp_t e;
      if (rst1_n) begin
         if (hold_prev) chk("res_stable", {c1.res_valid, c1.res_data, c1.res_op, c1.res_tag}, {1'b1, prev_res});
         hold_prev = c1.res_valid && !c1.res_ready;
         prev_res  = {c1.res_data, c1.res_op, c1.res_tag};
         if (c1.res_valid && c1.res_ready) begin
            chk("pop_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("res_data", c1.res_data, e.data);
               chk("res_op", c1.res_op, e.op);
               chk("res_tag", c1.res_tag, e.tag);
               last_tag = c1.res_tag;
               pops++;
            end
         end
         if (c1.cmd_valid && c1.cmd_ready) begin
            e.data = alu_ref(c1.cmd_op, c1.cmd_a, c1.cmd_b);
            e.op   = c1.cmd_op;
            e.tag  = mtag;
            exp_q.push_back(e);
            mtag = mtag + 3'd1;
         end
      end
   end

   task automatic send_wait(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input bit rnd_rdy);
      int n = 0;
      c1.cmd_op = op; c1.cmd_a = a; c1.cmd_b = b; c1.cmd_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (c1.cmd_ready || n >= 200) break;
         @(posedge clk); #1;
         n++;
         if (rnd_rdy) c1.res_ready = 1'($urandom_range(0, 1));
      end
      chk("accept_bound", (n < 200), 1);
      @(posedge clk); #1;
      c1.cmd_valid = 1'b0;
      if (rnd_rdy) c1.res_ready = 1'($urandom_range(0, 1));
   endtask

   // Directed single command into an empty FIFO with res_ready high.
   task automatic send_check(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                             input logic [4:0] exp_d, input logic [2:0] exp_tag);
      send_wait(op, a, b, 1'b0);
      @(negedge clk);
      chk("drv_en", c1.alu_en, 1);
      chk("drv_sel", {c1.alu_s1, c1.alu_s0}, op);
      chk("drv_a", c1.alu_a, a);
      chk("drv_b", c1.alu_b, b);
      chk("drv_cmd_ready", c1.cmd_ready, 0);
      chk("drv_busy", busy1, 1);
      @(negedge clk);
      chk("en_one_cycle", c1.alu_en, 0);
      chk("lat_res_valid", c1.res_valid, 1);
      chk("lat_res_data", c1.res_data, exp_d);
      chk("lat_res_op", c1.res_op, op);
      chk("lat_res_tag", c1.res_tag, exp_tag);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      c1.res_ready = 1'b1;
      while ((exp_q.size() != 0 || c1.res_valid) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_bound", (n < 100), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      int         en_run;
      int         rdy_hi;
      int         seen;
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] b;

      rst1_n = 1'b0; rst3_n = 1'b0;
      c1.cmd_valid = 1'b0; c1.cmd_op = '0; c1.cmd_a = '0; c1.cmd_b = '0; c1.res_ready = 1'b0;
      c3.cmd_valid = 1'b0; c3.cmd_op = '0; c3.cmd_a = '0; c3.cmd_b = '0; c3.res_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_alu_en", c1.alu_en, 0);
      chk("rst_alu_a", c1.alu_a, 0);
      chk("rst_res_valid", c1.res_valid, 0);
      chk("rst_res_data", c1.res_data, 0);
      chk("rst_busy", busy1, 0);
      chk("rst3_busy", busy3, 0);
      @(posedge clk); #1;
      rst1_n = 1'b1; rst3_n = 1'b1;
      @(negedge clk);
      chk("rel_cmd_ready", c1.cmd_ready, 1);
      @(posedge clk); #1;

      // Directed add / AND / compare
      c1.res_ready = 1'b1;
      send_check(2'b00, 4'd9, 4'd8, 5'b10001, 3'd0);
      send_check(2'b11, 4'b1100, 4'b1010, 5'b01000, 3'd1);
      send_check(2'b10, 4'd7, 4'd3, alu_ref(2'b10, 4'd7, 4'd3), 3'd2);
      send_check(2'b01, 4'd2, 4'd5, 5'b11101, 3'd3);

      // Back-pressure: four results fill the FIFO, fifth command waits for a pop
      @(posedge clk); #1 rst1_n = 1'b0; model_reset();
      @(posedge clk); #1 rst1_n = 1'b1;
      c1.res_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send_wait(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'b0);
      c1.cmd_op = 2'b00; c1.cmd_a = 4'd15; c1.cmd_b = 4'd15; c1.cmd_valid = 1'b1;
      seen = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (c1.cmd_ready) seen++;
         @(posedge clk); #1;
      end
      chk("bp_full_blocks", seen, 0);
      chk("bp_queued", exp_q.size(), 4);
      c1.res_ready = 1'b1;
      @(posedge clk); #1 c1.res_ready = 1'b0;
      chk("bp_first_tag", last_tag, 0);
      send_wait(2'b00, 4'd15, 4'd15, 1'b0);
      drain();
      chk("bp_pops", pops, 5);
      chk("bp_last_tag", last_tag, 4);

      // Tag wrap: nine commands give tags 0..7 then 0
      @(posedge clk); #1 rst1_n = 1'b0; model_reset();
      @(posedge clk); #1 rst1_n = 1'b1;
      c1.res_ready = 1'b1;
      for (int i = 0; i < 9; i++)
         send_wait(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'b0);
      drain();
      chk("wrap_pops", pops, 9);
      chk("wrap_last_tag", last_tag, 0);

      // Random ops with random consumer readiness
      for (int i = 0; i < 40; i++)
         send_wait(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'b1);
      drain();
      chk("rand_all_popped", exp_q.size(), 0);

      // Reset during DRIVE with two results queued
      c1.res_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send_wait(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'b0);
      @(negedge clk);
      chk("mid_drive_en", c1.alu_en, 1);
      chk("mid_queued", exp_q.size(), 3);
      #1 rst1_n = 1'b0; model_reset();
      #1;
      chk("async_alu_en", c1.alu_en, 0);
      chk("async_res_valid", c1.res_valid, 0);
      chk("async_busy", busy1, 0);
      @(posedge clk); #1 rst1_n = 1'b1;
      @(negedge clk);
      chk("post_rst_cmd_ready", c1.cmd_ready, 1);
      @(posedge clk); #1;
      c1.res_ready = 1'b1;
      a = 4'($urandom); b = 4'($urandom);
      send_check(2'b00, a, b, {1'b0, a} + {1'b0, b}, 3'd0);

      // SETTLE_CYCLES=3 instance
      for (int k = 0; k < 3; k++) begin
         op = 2'($urandom_range(0, 3)); a = 4'($urandom); b = 4'($urandom);
         c3.cmd_op = op; c3.cmd_a = a; c3.cmd_b = b; c3.cmd_valid = 1'b1;
         n = 0;
         @(negedge clk);
         while (!c3.cmd_ready && n < 50) begin @(negedge clk); n++; end
         chk("s3_accept_bound", (n < 50), 1);
         @(posedge clk); #1 c3.cmd_valid = 1'b0;
         en_run = 0; rdy_hi = 0; n = 0;
         @(negedge clk);
         while (c3.alu_en && n < 20) begin
            en_run++;
            if (c3.cmd_ready) rdy_hi++;
            @(negedge clk);
            n++;
         end
         chk("s3_en_cycles", en_run, 3);
         chk("s3_rdy_low", rdy_hi, 0);
         chk("s3_res_valid", c3.res_valid, 1);
         chk("s3_res_data", c3.res_data, alu_ref(op, a, b));
         chk("s3_res_op", c3.res_op, op);
         chk("s3_res_tag", c3.res_tag, k);
         @(posedge clk); #1 c3.res_ready = 1'b1;
         @(posedge clk); #1 c3.res_ready = 1'b0;
      end
      @(negedge clk);
      chk("s3_empty", c3.res_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator-side front end for the 4-bit combinational ALU (add/sub, compare, AND; 5-bit result).
- Accepts operation commands on a valid/ready stream and drives the ALU select, operand and enable pins for a programmable settle window.
- Captures the 5-bit result into a small result FIFO and returns it, tagged, on a second valid/ready stream.
- Sits between the system command bus and the ALU datapath.

Parameters:
- SETTLE_CYCLES, 1, cycles the ALU inputs are held with enable high before the result is sampled (>=1).
- RES_DEPTH, 4, result FIFO depth (power of 2, >=2).
- TAG_W, 3, width of the per-command sequence tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  2  00 add, 01 sub, 10 compare, 11 AND.
- cmd_a  in  4  operand a.
- cmd_b  in  4  operand b.
- alu_s0  out  1  ALU select bit 0.
- alu_s1  out  1  ALU select bit 1.
- alu_a  out  4  ALU operand a.
- alu_b  out  4  ALU operand b.
- alu_en  out  1  ALU enable.
- alu_y  in  5  ALU result (combinational from the alu_* outputs).
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer ready.
- res_data  out  5  captured ALU result.
- res_op  out  2  op that produced res_data.
- res_tag  out  TAG_W  sequence tag of the command.
- busy  out  1  high when not IDLE or FIFO non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; settle counter, tag counter and FIFO pointers/count are 0.
  - All outputs are 0, except cmd_ready, which follows its rule after release.
  - Asserting reset mid-operation drops the in-flight command and any queued results.
- Op encoding to ALU pins (S1,S0):
  - add = 0,0; sub = 0,1; compare = 1,0; AND = 1,1.
- States IDLE, DRIVE.
- IDLE:
  - alu_en=0; alu_s0/s1/a/b driven 0.
  - cmd_ready = (fifo_count < RES_DEPTH).
  - On cmd_valid&cmd_ready: latch op/a/b and the current tag; tag increments mod 2^TAG_W; settle counter loads SETTLE_CYCLES-1; next state DRIVE.
- DRIVE:
  - cmd_ready=0; alu_en=1; pins driven from the latched registers.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: push {alu_y, op, tag} into the FIFO at the clock edge and return to IDLE.
  - A new command may be accepted the cycle after return.
- No overflow by construction: the accept rule reserves a slot, and pops during DRIVE only free space.
- Latency: with SETTLE_CYCLES=1, command accepted at edge N, DRIVE during cycle N+1, result pushed at edge N+2. res_valid is high in cycle N+2 if the FIFO was empty.
- Throughput: one command per SETTLE_CYCLES+1 cycles.
- FIFO:
  - res_* reflect the head entry (registered storage, no fall-through combinational path from alu_y).
  - A pop occurs on res_valid&res_ready.
  - Simultaneous push and pop in one cycle is legal; count is unchanged.
  - Pointers wrap mod RES_DEPTH.
  - When full, cmd_ready=0 until a pop.
- res_valid/res_data/res_op/res_tag stay stable while res_valid&!res_ready.
- A cmd_valid held high across a busy period is not consumed until the handshake completes.
- No arithmetic in this block: alu_y is stored verbatim, full 5 bits.

Decomposition:
- Package alu_seq_pkg:
  - op encoding constants (OP_ADD, OP_SUB, OP_CMP, OP_AND);
  - state enum {IDLE, DRIVE};
  - function mapping op to {s1,s0}.
- Sub-module alu_res_fifo: parameterised synchronous FIFO, width 5+2+TAG_W, depth RES_DEPTH, clk/rst_n, push/pop, full/empty/count.

Test Plan:
- Bench instantiates the real ALU on the alu_* pins.
- Add: cmd_op=00, a=9, b=8, res_ready=1 -> alu_s1/s0=0/0 and alu_en=1 for exactly 1 cycle; res_valid 2 cycles after accept with res_data=5'b10001, res_op=00, res_tag=0.
- AND: cmd_op=11, a=4'b1100, b=4'b1010 -> alu_s1/s0=1/1; res_data=5'b01000, res_tag=1. Compare op 10 drives 1/0 and returns alu_y unchanged.
- Back-pressure: res_ready=0, issue 5 commands back-to-back -> 4 accepted, cmd_ready=0 after the 4th; single pop re-enables acceptance; results drain in order with tags 0..3 and then 4.
- SETTLE_CYCLES=3: alu_en high exactly 3 consecutive cycles per command; sample captured at the third cycle; cmd_ready low throughout.
- Tag wrap: 9 commands with TAG_W=3 -> tags 0..7, then 0.
- Reset: assert rst_n=0 during DRIVE with 2 results queued -> alu_en, res_valid and busy all 0 immediately (async); after release cmd_ready=1 and the next result's tag=0.
